// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port memory arbiter (VGA, IMEM, DMEM) onto one downstream
// request channel, with a single transaction outstanding at a time.
//
// Ports
//   CLOCK_50, RESET_N        clock; synchronous active-low reset
//   s_req/s_we [3]           per-port request and write flag (0 VGA, 1 IMEM, 2 DMEM)
//   s_addr/s_wdata/s_be      per-port request fields, port i at [i*W +: W]
//   s_gnt [3]                one-hot acceptance pulse (combinational on m_req && m_ready)
//   s_rvalid [3], s_rdata    registered one-hot read-return pulse and shared read data
//   m_req/m_we/m_addr/...    registered downstream request
//   m_ready                  downstream accepts the request when m_req && m_ready
//   m_rvalid, m_rdata        downstream read return (ignored outside WAIT_RD)
//
// Arbitration: VGA has priority unless it has already won STARVE_LIM selections
// in a row while a CPU port was waiting; IMEM and DMEM share round-robin.
module mem_arbiter #(
  parameter int unsigned AW         = 25,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_LIM = 4,
  localparam int unsigned BW        = DW / 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [2:0]        s_req,
  input  logic [2:0]        s_we,
  input  logic [3*AW-1:0]   s_addr,
  input  logic [3*DW-1:0]   s_wdata,
  input  logic [3*BW-1:0]   s_be,
  output logic [2:0]        s_gnt,
  output logic [2:0]        s_rvalid,
  output logic [DW-1:0]     s_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  output logic [BW-1:0]     m_be,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DW-1:0]     m_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIM + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t         state;
  logic [1:0]     owner;
  logic           last_dmem;   // round-robin pointer: 1 = DMEM was served last
  logic [CW-1:0]  starve_cnt;

  logic           cpu_req;
  logic           vga_ok;
  logic [1:0]     winner;

  // Winner selection, only consumed in IDLE with some request pending.
  always_comb begin
    cpu_req = s_req[1] | s_req[2];
    vga_ok  = s_req[0] && !(cpu_req && (starve_cnt == CW'(STARVE_LIM)));
    winner  = 2'd2;
    if (vga_ok)
      winner = 2'd0;
    else if (s_req[1] && s_req[2])
      winner = last_dmem ? 2'd1 : 2'd2;
    else if (s_req[1])
      winner = 2'd1;
  end

  always_comb begin
    s_gnt = '0;
    if (m_req && m_ready)
      s_gnt = 3'b001 << owner;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state      <= IDLE;
      owner      <= '0;
      last_dmem  <= 1'b1;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
      s_rvalid   <= '0;
      s_rdata    <= '0;
    end else begin
      s_rvalid <= '0;
      case (state)
        IDLE: begin
          if (|s_req) begin
            owner   <= winner;
            m_we    <= s_we[winner];
            m_addr  <= s_addr[winner*AW +: AW];
            m_wdata <= s_wdata[winner*DW +: DW];
            m_be    <= s_be[winner*BW +: BW];
            m_req   <= 1'b1;
            state   <= ISSUE;
            if (winner == 2'd0) begin
              // Only VGA wins taken at a waiting CPU's expense count toward starvation.
              if (cpu_req)
                starve_cnt <= starve_cnt + CW'(1);
            end else begin
              starve_cnt <= '0;
              last_dmem  <= (winner == 2'd2);
            end
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_req <= 1'b0;
            state <= m_we ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (m_rvalid) begin
            s_rdata  <= m_rdata;
            s_rvalid <= 3'b001 << owner;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A transaction-level model
// predicts every output each cycle; directed sequences add literal expectations.
module tb_mem_arbiter;

  localparam int unsigned AW  = 25;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned LIM = 4;

  logic              clk = 1'b0;
  logic              RESET_N;
  logic [2:0]        s_req;
  logic [2:0]        s_we;
  logic [3*AW-1:0]   s_addr;
  logic [3*DW-1:0]   s_wdata;
  logic [3*BW-1:0]   s_be;
  logic [2:0]        s_gnt;
  logic [2:0]        s_rvalid;
  logic [DW-1:0]     s_rdata;
  logic              m_req;
  logic              m_we;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [BW-1:0]     m_be;
  logic              m_ready;
  logic              m_rvalid;
  logic [DW-1:0]     m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .CLOCK_50(clk), .RESET_N(RESET_N),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            mdl_valid = 0;
  bit            mdl_issue, mdl_wait;
  int            mdl_owner;
  logic          mdl_we;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wdata;
  logic [BW-1:0] mdl_be;
  logic [2:0]    mdl_rvalid;
  logic [DW-1:0] mdl_rdata;
  int            vga_streak;
  int            last_cpu;

  function automatic int pick(input logic [2:0] rq, input int streak, input int last);
    bit cpu_waiting;
    cpu_waiting = rq[1] || rq[2];
    if (rq[0] && !(cpu_waiting && streak >= int'(LIM))) return 0;
    if (rq[1] && rq[2]) return (last == 1) ? 2 : 1;
    return rq[1] ? 1 : 2;
  endfunction

  initial begin
    logic [2:0] exp_gnt;
    int w;
    forever begin
      @(negedge clk);
      if (mdl_valid) begin
        exp_gnt = (mdl_issue && m_ready) ? (3'b001 << mdl_owner) : 3'b000;
        check("s_gnt", 64'(s_gnt), 64'(exp_gnt));
        check("s_rvalid", 64'(s_rvalid), 64'(mdl_rvalid));
        check("s_rdata", 64'(s_rdata), 64'(mdl_rdata));
        check("m_req", 64'(m_req), 64'(mdl_issue));
        check("m_we", 64'(m_we), 64'(mdl_we));
        check("m_addr", 64'(m_addr), 64'(mdl_addr));
        check("m_wdata", 64'(m_wdata), 64'(mdl_wdata));
        check("m_be", 64'(m_be), 64'(mdl_be));
      end
      // Inputs seen now are the ones the next rising edge samples.
      if (!RESET_N) begin
        mdl_valid = 1; mdl_issue = 0; mdl_wait = 0; mdl_owner = 0;
        mdl_we = 0; mdl_addr = '0; mdl_wdata = '0; mdl_be = '0;
        mdl_rvalid = '0; mdl_rdata = '0; vga_streak = 0; last_cpu = 2;
      end else if (mdl_valid) begin
        mdl_rvalid = '0;
        if (mdl_issue) begin
          if (m_ready) begin
            mdl_issue = 0;
            mdl_wait  = !mdl_we;
          end
        end else if (mdl_wait) begin
          if (m_rvalid) begin
            mdl_rvalid = 3'b001 << mdl_owner;
            mdl_rdata  = m_rdata;
            mdl_wait   = 0;
          end
        end else if (s_req != 3'b000) begin
          w = pick(s_req, vga_streak, last_cpu);
          if (w == 0) begin
            if (s_req[1] || s_req[2]) vga_streak++;
          end else begin
            vga_streak = 0;
            last_cpu   = w;
          end
          mdl_owner = w;
          mdl_we    = s_we[w];
          mdl_addr  = s_addr[w*AW +: AW];
          mdl_wdata = s_wdata[w*DW +: DW];
          mdl_be    = s_be[w*BW +: BW];
          mdl_issue = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic rq, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
    s_req[i]           = rq;
    s_we[i]            = wr;
    s_addr[i*AW +: AW] = a;
    s_wdata[i*DW +: DW] = d;
    s_be[i*BW +: BW]   = b;
  endtask

  task automatic wait_gnt(output logic [2:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_gnt != 3'b000) begin
        g = s_gnt;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL gnt_timeout: no grant within 20 cycles at %0t", $time);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    logic [2:0] exp_seq34 [6] = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
    logic [2:0] exp_seq35 [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};

    RESET_N = 0; s_req = '0; s_we = '0; s_addr = '0; s_wdata = '0; s_be = '0;
    m_ready = 1; m_rvalid = 0; m_rdata = '0;
    repeat (3) tick();
    RESET_N = 1;
    @(negedge clk);
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_s_rdata", 64'(s_rdata), 64'd0);
    check("rst_s_gnt", 64'(s_gnt), 64'd0);

    // Single IMEM read, data returned 2 cycles after acceptance.
    tick(); set_port(1, 1, 0, 25'h100, '0, '0);
    tick();
    @(negedge clk);
    check("rd_gnt", 64'(s_gnt), 64'b010);
    check("rd_m_addr", 64'(m_addr), 64'h100);
    tick(); s_req = '0;
    tick(); m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    tick(); m_rvalid = 0; m_rdata = '0;
    @(negedge clk);
    check("rd_rvalid", 64'(s_rvalid), 64'b010);
    check("rd_rdata", 64'(s_rdata), 64'hDEADBEEF);
    tick();
    @(negedge clk);
    check("rd_rvalid_pulse", 64'(s_rvalid), 64'd0);

    // VGA and DMEM write together: VGA first, DMEM issued two cycles later.
    tick();
    set_port(0, 1, 1, 25'h10, 32'h11111111, 4'hF);
    set_port(2, 1, 1, 25'h2A0, 32'hCAFEF00D, 4'b0101);
    tick();
    @(negedge clk);
    check("vd_gnt_vga", 64'(s_gnt), 64'b001);
    check("vd_addr_vga", 64'(m_addr), 64'h10);
    tick(); s_req[0] = 0;
    tick();
    @(negedge clk);
    check("vd_gnt_dmem", 64'(s_gnt), 64'b100);
    check("vd_addr_dmem", 64'(m_addr), 64'h2A0);
    check("vd_wdata_dmem", 64'(m_wdata), 64'hCAFEF00D);
    check("vd_be_dmem", 64'(m_be), 64'b0101);
    tick(); s_req = '0;
    tick();

    // IMEM/DMEM continuous writes after reset alternate starting with IMEM.
    RESET_N = 0;
    tick(); RESET_N = 1;
    set_port(1, 1, 1, 25'h200, 32'hA0A0A0A0, 4'hF);
    set_port(2, 1, 1, 25'h300, 32'hB0B0B0B0, 4'h3);
    for (int k = 0; k < 6; k++) begin
      wait_gnt(g);
      check($sformatf("rr_gnt%0d", k), 64'(g), 64'(exp_seq34[k]));
    end
    tick(); s_req = '0;
    tick();

    // Starvation: four VGA wins, one DMEM, then VGA again.
    set_port(0, 1, 1, 25'h40, 32'h0000_0040, 4'hF);
    set_port(2, 1, 1, 25'h380, 32'h0000_0380, 4'hC);
    for (int k = 0; k < 6; k++) begin
      wait_gnt(g);
      check($sformatf("starve_gnt%0d", k), 64'(g), 64'(exp_seq35[k]));
      if (g == 3'b100) begin
        tick(); s_req[2] = 0;
      end
    end
    tick(); s_req = '0;
    tick();

    // Back-pressure: request fields stay put while inputs wiggle.
    m_ready = 0;
    set_port(1, 1, 1, 25'h1ABC, 32'h5, 4'hF);
    tick();
    for (int k = 0; k < 10; k++) begin
      s_addr[AW +: AW] = s_addr[AW +: AW] ^ 25'h1FFFFFF;
      s_req[0] = ~s_req[0];
      @(negedge clk);
      check("bp_addr", 64'(m_addr), 64'h1ABC);
      check("bp_gnt", 64'(s_gnt), 64'd0);
      tick();
    end
    s_req[0] = 0; m_ready = 1;
    @(negedge clk);
    check("bp_gnt_rel", 64'(s_gnt), 64'b010);
    check("bp_addr_rel", 64'(m_addr), 64'h1ABC);
    tick(); s_req = '0;
    tick();

    // DMEM read, acceptance delayed one cycle, data in first WAIT_RD cycle.
    m_ready = 0;
    set_port(2, 1, 0, 25'h3FF, '0, '0);
    tick();
    tick(); m_ready = 1;
    tick(); s_req = '0; m_rvalid = 1; m_rdata = 32'h12345678;
    tick(); m_rvalid = 0; m_rdata = '0;
    @(negedge clk);
    check("dr_rvalid", 64'(s_rvalid), 64'b100);
    check("dr_rdata", 64'(s_rdata), 64'h12345678);

    // Reset during WAIT_RD abandons the read; the late return is dropped.
    tick(); set_port(1, 1, 0, 25'h77, '0, '0);
    tick();
    tick(); s_req = '0;
    tick(); RESET_N = 0;
    tick(); RESET_N = 1; m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
    tick(); m_rvalid = 0; m_rdata = '0;
    @(negedge clk);
    check("rst_rd_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_rd_m_req", 64'(m_req), 64'd0);
    check("rst_rd_rdata", 64'(s_rdata), 64'd0);
    tick();
    @(negedge clk);
    check("rst_rd_rvalid2", 64'(s_rvalid), 64'd0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
